// File: rtl/dco_freq_counter.sv
// rtl/dco_freq_counter.sv - DCO frequency counter: measures ref_in periods in clk_in cycles and flags lock
//
// Ports:
//   clk_in      DCO clock, the only clock domain
//   reset       asynchronous active-high reset
//   ref_in      reference clock, asynchronous to clk_in (synchronized internally)
//   enable      measurement enable; low forces IDLE and clears lock state
//   target      expected clk_in cycles per ref_in period
//   tol         allowed absolute deviation from target
//   count_out   last measured ref_in period (saturates at 2^CNT_W-1)
//   count_valid one-cycle pulse when count_out updates
//   overflow    one-cycle pulse when a period exceeds the counter range
//   locked      level, high after LOCK_N consecutive in-tolerance periods
module dco_freq_counter #(
    parameter int CNT_W  = 16,
    parameter int TOL_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] target,
    input  logic [TOL_W-1:0] tol,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             locked
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_N);
    localparam int               DW       = (CNT_W + 1 > TOL_W) ? CNT_W + 1 : TOL_W;

    state_t           state, state_next;
    logic             ref_s1, ref_s2, ref_s3;
    logic             ref_edge;
    logic [CNT_W-1:0] counter;
    logic [3:0]       streak, streak_next;
    logic             meas_done, sat_hit;
    logic [CNT_W-1:0] meas_val;
    logic [CNT_W:0]   meas_ext, target_ext, diff;
    logic [DW-1:0]    dev_cmp, tol_cmp;
    logic             in_tol;

    assign ref_edge = ref_s2 & ~ref_s3;

    // An edge arriving with the counter already saturated would be 2^CNT_W;
    // clamp it rather than let it wrap to 0.
    assign meas_val   = (counter == CNT_MAX) ? CNT_MAX : counter + 1'b1;
    assign meas_ext   = {1'b0, meas_val};
    assign target_ext = {1'b0, target};
    assign diff       = (meas_ext >= target_ext) ? meas_ext - target_ext : target_ext - meas_ext;
    assign dev_cmp    = DW'(diff);
    assign tol_cmp    = DW'(tol);
    assign in_tol     = (dev_cmp <= tol_cmp);

    always_comb begin
        streak_next = 4'd0;
        if (in_tol) begin
            streak_next = (streak >= LOCK_TGT) ? LOCK_TGT : streak + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        meas_done  = 1'b0;
        sat_hit    = 1'b0;
        case (state)
            IDLE:    state_next = ARM;
            ARM:     if (ref_edge) state_next = MEASURE;
            MEASURE: begin
                if (ref_edge) begin
                    meas_done = 1'b1;
                end else if (counter == CNT_MAX) begin
                    sat_hit    = 1'b1;
                    state_next = ARM;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
            meas_done  = 1'b0;
            sat_hit    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ref_s1      <= 1'b0;
            ref_s2      <= 1'b0;
            ref_s3      <= 1'b0;
            counter     <= '0;
            streak      <= 4'd0;
            count_out   <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            ref_s1      <= ref_in;
            ref_s2      <= ref_s1;
            ref_s3      <= ref_s2;
            count_valid <= meas_done;
            overflow    <= sat_hit;
            if (!enable) begin
                counter <= '0;
                streak  <= 4'd0;
                locked  <= 1'b0;
            end else if (state == MEASURE) begin
                if (meas_done) begin
                    count_out <= meas_val;
                    counter   <= '0;
                    streak    <= streak_next;
                    locked    <= (streak_next == LOCK_TGT);
                end else if (sat_hit) begin
                    counter <= '0;
                    streak  <= 4'd0;
                    locked  <= 1'b0;
                end else begin
                    counter <= counter + 1'b1;
                end
            end else begin
                counter <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dco_freq_counter.sv
// tb/tb_dco_freq_counter.sv - self-checking bench for dco_freq_counter with a period-level reference model
module tb_dco_freq_counter;

    localparam int CW   = 4;
    localparam int MAXC = 15;
    localparam int FULL = 16;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          ref_in = 1'b0;
    logic          enable;
    logic [CW-1:0] target;
    logic [7:0]    tol;
    logic [CW-1:0] count_out;
    logic          count_valid;
    logic          overflow;
    logic          locked;

    int errors = 0;
    int checks = 0;

    int per    = 8;
    int inject = 0;
    bit ref_run = 1'b1;

    dco_freq_counter #(.CNT_W(CW), .TOL_W(8), .LOCK_N(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .ref_in      (ref_in),
        .enable      (enable),
        .target      (target),
        .tol         (tol),
        .count_out   (count_out),
        .count_valid (count_valid),
        .overflow    (overflow),
        .locked      (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference clock: one rising edge every p clk_in cycles, changes on negedges.
    always begin
        int p;
        @(negedge clk_in);
        if (!ref_run) begin
            ref_in = 1'b0;
        end else begin
            p = (inject != 0) ? inject : per;
            inject = 0;
            ref_in = 1'b1;
            repeat (p / 2) @(negedge clk_in);
            ref_in = 1'b0;
            repeat (p - p / 2 - 1) @(negedge clk_in);
        end
    end

    // Reference model: a rise of ref_in is seen by the design two sampling
    // edges later; a period is the edge-count distance between seen rises.
    int   cyc = 0;
    logic q[$];
    int   mode, arm_cyc, good_run, elapsed, dev;
    bit   ref_rise;
    int   e_count, e_valid, e_ovf, e_locked;

    always begin
        @(posedge clk_in);
        cyc++;
        if (reset) begin
            q = '{1'b0, 1'b0, 1'b0};
            mode = 0; good_run = 0;
            e_count = 0; e_valid = 0; e_ovf = 0; e_locked = 0;
        end else begin
            ref_rise = q[1] && !q[0];
            q.push_back(ref_in);
            void'(q.pop_front());
            e_valid = 0;
            e_ovf   = 0;
            if (!enable) begin
                mode = 0; good_run = 0; e_locked = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (ref_rise) begin
                    mode = 2; arm_cyc = cyc;
                end
            end else begin
                elapsed = cyc - arm_cyc;
                if (ref_rise) begin
                    e_count = (elapsed > MAXC) ? MAXC : elapsed;
                    e_valid = 1;
                    dev = e_count - int'(target);
                    if (dev < 0) dev = -dev;
                    good_run = (dev <= int'(tol)) ? good_run + 1 : 0;
                    e_locked = (good_run >= 4) ? 1 : 0;
                    arm_cyc = cyc;
                end else if (elapsed == FULL) begin
                    e_ovf = 1; good_run = 0; e_locked = 0; mode = 1;
                end
            end
        end
        #1;
        chk("model_count_out", int'(count_out), e_count);
        chk("model_count_valid", int'(count_valid), e_valid);
        chk("model_overflow", int'(overflow), e_ovf);
        chk("model_locked", int'(locked), e_locked);
        if (count_valid && overflow) chk("valid_ovf_exclusive", 1, 0);
    end

    task automatic wait_valid(input int bound, output int waited);
        waited = 0;
        do begin
            @(posedge clk_in); #1;
            waited++;
        end while (!count_valid && waited < bound);
        chk("valid_timeout", int'(count_valid), 1);
    endtask

    task automatic wait_count(input string name, input int val, input int tries);
        int w;
        int n = 0;
        do begin
            wait_valid(40, w);
            n++;
        end while (int'(count_out) != val && n < tries);
        chk(name, int'(count_out), val);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        int ovf_seen;
        reset = 1'b1; enable = 1'b0; target = 4'd8; tol = 8'd0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset_count_out", int'(count_out), 0);
        chk("reset_count_valid", int'(count_valid), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_locked", int'(locked), 0);
        @(negedge clk_in); reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // Period 8, exact target: lock on the 4th valid.
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(40, w);
            chk("p8_count", int'(count_out), 8);
            chk("p8_locked", int'(locked), (i == 4) ? 1 : 0);
        end

        // Period 10 with tol=1 never locks; tol=2 locks after 4 valids.
        @(negedge clk_in); per = 10; tol = 8'd1;
        wait_count("p10_first", 10, 3);
        chk("p10_unlocked", int'(locked), 0);
        for (int i = 0; i < 3; i++) begin
            wait_valid(40, w);
            chk("p10_count", int'(count_out), 10);
            chk("p10_tol1_locked", int'(locked), 0);
        end
        @(negedge clk_in); tol = 8'd2;
        for (int i = 1; i <= 4; i++) begin
            wait_valid(40, w);
            chk("p10_tol2_locked", int'(locked), (i == 4) ? 1 : 0);
        end

        // Locked at 8, inject one 12-cycle period.
        @(negedge clk_in); per = 8; tol = 8'd1;
        n = 0;
        do begin wait_valid(40, w); n++; end while (!(locked && count_out == 8) && n < 10);
        chk("p8_relock", int'(locked), 1);
        @(negedge clk_in); inject = 12;
        wait_count("inject_12", 12, 3);
        chk("inject_unlock", int'(locked), 0);
        for (int i = 1; i <= 4; i++) begin
            wait_valid(40, w);
            chk("after_inject_count", int'(count_out), 8);
            chk("after_inject_locked", int'(locked), (i == 4) ? 1 : 0);
        end

        // One-cycle enable drop while locked.
        @(negedge clk_in); @(negedge clk_in);
        enable = 1'b0;
        @(posedge clk_in); #1;
        chk("en_drop_locked", int'(locked), 0);
        chk("en_drop_valid", int'(count_valid), 0);
        @(negedge clk_in); enable = 1'b1;
        wait_valid(40, w);
        chk("en_drop_gap_ge9", (w >= 9) ? 1 : 0, 1);
        chk("en_drop_count", int'(count_out), 8);
        chk("en_drop_relocked", int'(locked), 0);

        // Reset pulse mid-period: outputs clear immediately.
        @(negedge clk_in); @(negedge clk_in);
        reset = 1'b1;
        #1;
        chk("async_rst_count", int'(count_out), 0);
        chk("async_rst_valid", int'(count_valid), 0);
        chk("async_rst_ovf", int'(overflow), 0);
        chk("async_rst_locked", int'(locked), 0);
        @(negedge clk_in); reset = 1'b0;
        wait_valid(40, w);
        chk("rst_gap_ge9", (w >= 9) ? 1 : 0, 1);
        chk("rst_count", int'(count_out), 8);

        // Boundaries: 15 fits, 16 clamps to 15, then ref stops -> one overflow.
        @(negedge clk_in); per = 15;
        wait_count("p15_count", 15, 3);
        @(negedge clk_in); per = 16;
        wait_valid(40, w); wait_valid(40, w);
        chk("p16_clamped", int'(count_out), 15);
        @(negedge clk_in); per = 8;
        wait_count("p8_before_stop", 8, 4);
        @(negedge clk_in); ref_run = 1'b0;
        ovf_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_in); #1;
            if (overflow) begin
                ovf_seen++;
                chk("ovf_count_kept", int'(count_out), 8);
            end
            if (ovf_seen > 0) chk("ovf_locked_low", int'(locked), 0);
        end
        chk("ovf_once", ovf_seen, 1);
        @(negedge clk_in); ref_run = 1'b1;
        wait_count("after_ovf_count", 8, 2);

        // Randomized periods, targets, tolerances, enable drops and resets.
        for (int it = 0; it < 60; it++) begin
            int r;
            @(negedge clk_in);
            per = $urandom_range(2, 18);
            target = ($urandom_range(0, 1) == 1) ? CW'((per > 15) ? 15 : per) : CW'($urandom_range(0, 15));
            tol = 8'($urandom_range(0, 3));
            repeat (per * 5 + $urandom_range(0, 5)) @(negedge clk_in);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_in);
                enable = 1'b1;
            end else if (r == 1) begin
                reset = 1'b1;
                @(negedge clk_in);
                reset = 1'b0;
            end
        end
        repeat (20) @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dco_freq_counter.md
DCO_FREQ_COUNTER -- requirements
Module: dco_freq_counter

Interface
REQ-001 Parameter CNT_W, default 16, width of the period counter, count_out and target.
REQ-002 Parameter TOL_W, default 8, width of tol.
REQ-003 Parameter LOCK_N, default 4, number of consecutive in-tolerance measurements needed for lock (range 1..15).
REQ-004 Port clk_in, input, 1, DCO clock; the only clock; all state SHALL be on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port ref_in, input, 1, reference/divided clock, asynchronous to clk_in.
REQ-007 Port enable, input, 1, measurement enable, synchronous to clk_in.
REQ-008 Port target, input, CNT_W, expected clk_in cycles per ref_in period.
REQ-009 Port tol, input, TOL_W, allowed absolute deviation from target.
REQ-010 Port count_out, output, CNT_W, last measured ref_in period in clk_in cycles.
REQ-011 Port count_valid, output, 1, one-cycle pulse when count_out updates.
REQ-012 Port overflow, output, 1, one-cycle pulse when the period counter saturates.
REQ-013 Port locked, output, 1, frequency-lock indication, level.

Function
REQ-014 ref_in SHALL pass through a 2-flop synchronizer; a rising edge (ref_edge) SHALL be a third flop at 0 and the second sync flop at 1, a single-cycle event.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-016 In any state, enable=0 SHALL force IDLE next cycle, clear counter, streak and locked, and suppress count_valid.
REQ-017 IDLE with enable=1 SHALL go to ARM next cycle.
REQ-018 ARM SHALL wait for ref_edge; on ref_edge go to MEASURE with counter<=0; no count_valid from ARM.
REQ-019 In MEASURE, a cycle without ref_edge SHALL increment counter by 1.
REQ-020 In MEASURE, a ref_edge cycle SHALL load count_out<=counter+1, pulse count_valid the next cycle with count_out, clear counter to 0, and stay in MEASURE; a ref_in period of P clk_in cycles yields count_out=P.
REQ-021 If counter reaches 2^CNT_W-1 in MEASURE without ref_edge, the next cycle SHALL pulse overflow, leave count_out unchanged, clear streak and locked, and go to ARM.
REQ-022 If ref_edge and saturation coincide, the ref_edge path SHALL win, count_out=2^CNT_W (truncated to 0 not permitted): count_out SHALL saturate at 2^CNT_W-1.
REQ-023 Deviation SHALL be |count_out_new - target| computed at CNT_W+1 bits, no wrap.
REQ-024 On each count_valid, deviation<=tol SHALL increment streak (saturating at LOCK_N); otherwise streak<=0.
REQ-025 locked SHALL be 1 exactly when streak==LOCK_N, updating in the same cycle as count_valid.
REQ-026 A change of target or tol SHALL take effect at the next measurement; no retroactive re-evaluation.
REQ-027 count_valid and overflow SHALL never be asserted in the same cycle.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, synchronizer flops 0, counter 0, streak 0, count_out 0, count_valid 0, overflow 0, locked 0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial count; after release, the first count_valid SHALL require a fresh ARM edge plus one full period.
REQ-030 Reset deassertion SHALL be handled as ordinary release; no output glitch beyond the values in REQ-028.

Verification
REQ-031 ref_in period 8 clk_in cycles, enable=1, target=8, tol=0 -> count_out=8 every 8 cycles; locked=1 with the 4th count_valid.
REQ-032 Period 10, target=8, tol=1 -> count_out=10, locked stays 0; then tol=2 -> locked=1 after 4 further valids.
REQ-033 CNT_W=4, ref_in held low after arming -> overflow pulse once, state ARM, locked=0, count_out unchanged.
REQ-034 Locked at period 8, one period of 12 injected (tol=1) -> locked drops with that count_valid, re-asserts after 4 good periods.
REQ-035 enable=0 for 1 cycle mid-period while locked -> locked=0 next cycle, no count_valid until ARM edge plus one full period.
REQ-036 reset pulse mid-period -> all outputs 0 immediately (asynchronous), recovery identical to REQ-035.
